// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM external bus arbiter: FSM encodings and
// the ctrl stall-vector bit positions the arbiter listens to.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2
    } arb_state_e;

    localparam int STALL_IF  = 1;
    localparam int STALL_MEM = 4;

endpackage

// File: rtl/mem_bus_arbiter_port_hold.sv
// Per-stage return path: done flag, hold register and the mux that returns
// live bus data in the completion cycle and held data afterwards.
module arb_port_hold
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              cmpl_i,
    input  logic              tmo_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              done_o,
    output logic [DATA_W-1:0] data_o
);

    logic              done_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] ret_data;

    // An aborted access completes with zero data so the stage can move on.
    assign ret_data = tmo_i ? '0 : bus_rdata_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            hold_q <= '0;
        end else if (!hold_i) begin
            done_q <= 1'b0;
        end else if (cmpl_i) begin
            done_q <= 1'b1;
            hold_q <= ret_data;
        end
    end

    assign done_o = done_q;
    assign data_o = cmpl_i ? ret_data : hold_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port bus arbiter between instruction fetch and data access; data
// accesses win, every transfer is guarded by a no-ack timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o,
    output logic [1:0]        dbg_state_o
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic i_done;
    logic d_done;
    logic busy;
    logic tmo_hit;
    logic xfer_end;
    logic i_cmpl;
    logic d_cmpl;
    logic pend_i;
    logic pend_d;
    logic unused_stall;

    assign busy     = (state_q != ARB_IDLE);
    assign tmo_hit  = busy & !bus_ack_i & (cnt_q == CNT_W'(TIMEOUT - 1));
    assign xfer_end = busy & (bus_ack_i | tmo_hit);
    assign i_cmpl   = (state_q == ARB_IBUSY) & xfer_end;
    assign d_cmpl   = (state_q == ARB_DBUSY) & xfer_end;
    assign pend_d   = mem_ce_i & !d_done;
    assign pend_i   = if_ce_i & !i_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (pend_d) begin
                        state_q <= ARB_DBUSY;
                        req_q   <= 1'b1;
                        we_q    <= mem_we_i;
                        addr_q  <= mem_addr_i;
                        wdata_q <= mem_wdata_i;
                        cnt_q   <= '0;
                    end else if (pend_i) begin
                        state_q <= ARB_IBUSY;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= if_addr_i;
                        wdata_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                ARB_IBUSY, ARB_DBUSY: begin
                    // Always drop back to IDLE so transfers are separated by one idle cycle.
                    if (xfer_end) begin
                        state_q <= ARB_IDLE;
                        req_q   <= 1'b0;
                        err_q   <= tmo_hit;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    arb_port_hold #(.DATA_W(DATA_W)) u_if_hold (
        .clk         (clk),
        .rst         (rst),
        .hold_i      (stall_i[STALL_IF]),
        .cmpl_i      (i_cmpl),
        .tmo_i       (tmo_hit),
        .bus_rdata_i (bus_rdata_i),
        .done_o      (i_done),
        .data_o      (if_data_o)
    );

    arb_port_hold #(.DATA_W(DATA_W)) u_mem_hold (
        .clk         (clk),
        .rst         (rst),
        .hold_i      (stall_i[STALL_MEM]),
        .cmpl_i      (d_cmpl),
        .tmo_i       (tmo_hit),
        .bus_rdata_i (bus_rdata_i),
        .done_o      (d_done),
        .data_o      (mem_rdata_o)
    );

    // Stall requests never look at stall_i, so ctrl sees no combinational loop.
    assign stallreq_if_o  = !rst & if_ce_i & !i_done & !i_cmpl;
    assign stallreq_mem_o = !rst & mem_ce_i & !d_done & !d_cmpl;

    assign bus_req_o    = req_q;
    assign bus_we_o     = we_q;
    assign bus_addr_o   = addr_q;
    assign bus_wdata_o  = wdata_q;
    assign bus_err_o    = err_q;
    assign dbg_state_o  = state_q;
    assign unused_stall = ^stall_i;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus pushes expected bus transfers
// and return data; negedge monitors pop and compare.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;
    logic [1:0]  dbg_state_o;

    typedef struct packed {
        logic [7:0]  len;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    bus_exp_t    exp_bus_q[$];
    logic [31:0] exp_if_q[$];
    logic [32:0] exp_mem_q[$];
    logic [31:0] mem_model [logic [31:0]];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_delay = 0;
    int req_cyc = 0;
    int if_done_cyc = -1;
    int mem_done_cyc = -1;
    int err_cyc = -1;
    int err_cnt = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .if_ce_i        (if_ce_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .mem_ce_i       (mem_ce_i),
        .mem_we_i       (mem_we_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .stallreq_if_o  (stallreq_if_o),
        .stallreq_mem_o (stallreq_mem_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_rdata_i    (bus_rdata_i),
        .bus_ack_i      (bus_ack_i),
        .bus_err_o      (bus_err_o),
        .dbg_state_o    (dbg_state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=missing-or-extra expected=matching-event", name);
    endtask

    // bus slave: read data visible whenever req is up, ack after ack_delay req cycles (-1 = never)
    always @(posedge clk) begin
        #1;
        if (bus_req_o) begin
            bus_rdata_i = model_rd(bus_addr_o);
            bus_ack_i   = (ack_delay >= 0) && (req_cyc == ack_delay);
            if (bus_ack_i && bus_we_o) mem_model[bus_addr_o] = bus_wdata_o;
            req_cyc++;
        end else begin
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'h0;
            req_cyc     = 0;
        end
    end

    // bus monitor
    logic     in_req = 1'b0;
    int       blen = 0;
    bus_exp_t be;
    always @(negedge clk) begin
        if (bus_req_o) begin
            if (!in_req) begin
                in_req = 1'b1;
                blen   = 0;
                if (exp_bus_q.size() == 0) fail_now("bus_unexpected_req");
            end
            blen++;
            if (exp_bus_q.size() > 0) begin
                be = exp_bus_q[0];
                check("bus_addr", bus_addr_o, be.addr);
                check("bus_we", bus_we_o, be.we);
                if (be.we) check("bus_wdata", bus_wdata_o, be.wdata);
            end
        end else if (in_req) begin
            in_req = 1'b0;
            if (exp_bus_q.size() > 0) begin
                be = exp_bus_q.pop_front();
                check("bus_req_len", blen, be.len);
            end
        end
    end

    // return-data monitor: a stall request falling while ce is held marks a completion
    logic        if_prev = 1'b0;
    logic        mem_prev = 1'b0;
    logic [32:0] me;
    always @(negedge clk) begin
        if (!rst && if_ce_i && if_prev && !stallreq_if_o) begin
            if_done_cyc = cyc;
            if (exp_if_q.size() == 0) fail_now("if_unexpected_done");
            else check("if_data", if_data_o, exp_if_q.pop_front());
        end
        if (!rst && mem_ce_i && mem_prev && !stallreq_mem_o) begin
            mem_done_cyc = cyc;
            if (exp_mem_q.size() == 0) fail_now("mem_unexpected_done");
            else begin
                me = exp_mem_q.pop_front();
                if (me[32]) check("mem_rdata", mem_rdata_o, me[31:0]);
            end
        end
        if_prev  = stallreq_if_o;
        mem_prev = stallreq_mem_o;
        if (bus_err_o) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    // driver tasks
    task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] wd, input int len);
        bus_exp_t e;
        e.len   = 8'(len);
        e.we    = we;
        e.addr  = a;
        e.wdata = wd;
        exp_bus_q.push_back(e);
    endtask

    task automatic wait_done(input bit is_mem, input string name);
        bit seen_hi = 1'b0;
        bit s;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            s = is_mem ? stallreq_mem_o : stallreq_if_o;
            if (s) seen_hi = 1'b1;
            else if (seen_hi) return;
        end
        fail_now(name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_i = 6'b0;
        if_ce_i = 1'b0; if_addr_i = 32'h0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
        bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
        mem_model[32'h0000_0040] = 32'h2401_0005;
        mem_model[32'h0000_0044] = 32'h3333_4444;
        mem_model[32'h0000_0048] = 32'h8C22_0000;
        mem_model[32'h0000_004C] = 32'h0043_0013;
        mem_model[32'h0000_1000] = 32'h1111_2222;
        mem_model[32'h0000_3000] = 32'h5555_AAAA;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", bus_req_o, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_bus_req", bus_req_o, 0);
        check("reset_bus_err", bus_err_o, 0);
        check("reset_bus_addr", bus_addr_o, 0);
        check("reset_if_data", if_data_o, 0);
        check("reset_mem_rdata", mem_rdata_o, 0);
        check("reset_state", dbg_state_o, 0);

        // fetch with ack in the first request cycle
        step();
        ack_delay = 0;
        push_bus(1'b0, 32'h40, 32'h0, 1);
        exp_if_q.push_back(32'h2401_0005);
        if_ce_i = 1'b1; if_addr_i = 32'h40;
        wait_done(1'b0, "t1_if_done_timeout");
        step();
        if_ce_i = 1'b0;
        repeat (2) step();

        // simultaneous load and fetch: data first, fetch after an idle cycle
        ack_delay = 1;
        push_bus(1'b0, 32'h1000, 32'h0, 2);
        push_bus(1'b0, 32'h44, 32'h0, 2);
        exp_mem_q.push_back({1'b1, 32'h1111_2222});
        exp_if_q.push_back(32'h3333_4444);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h1000;
        if_ce_i = 1'b1; if_addr_i = 32'h44;
        fork
            begin
                wait_done(1'b1, "t2_mem_done_timeout");
                step();
                mem_ce_i = 1'b0;
            end
            begin
                wait_done(1'b0, "t2_if_done_timeout");
                step();
                if_ce_i = 1'b0;
            end
        join
        check("t2_if_after_mem_cycles", 64'(if_done_cyc - mem_done_cyc), 3);
        repeat (2) step();

        // fetch completes while IF/ID is held for three more cycles
        ack_delay = 0;
        push_bus(1'b0, 32'h48, 32'h0, 1);
        exp_if_q.push_back(32'h8C22_0000);
        stall_i = 6'b000010;
        if_ce_i = 1'b1; if_addr_i = 32'h48;
        wait_done(1'b0, "t3_if_done_timeout");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_data", if_data_o, 32'h8C22_0000);
            check("t3_no_stallreq", stallreq_if_o, 0);
            check("t3_no_bus_req", bus_req_o, 0);
        end
        step();
        stall_i = 6'b0; if_addr_i = 32'h4C;
        push_bus(1'b0, 32'h4C, 32'h0, 1);
        exp_if_q.push_back(32'h0043_0013);
        wait_done(1'b0, "t3_refetch_timeout");
        step();
        if_ce_i = 1'b0;
        repeat (2) step();

        // store: bus fields stay registered even when the core's wdata moves
        ack_delay = 2;
        push_bus(1'b1, 32'h2000, 32'hDEAD_BEEF, 3);
        exp_mem_q.push_back({1'b0, 32'h0});
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h2000; mem_wdata_i = 32'hDEAD_BEEF;
        step();
        mem_wdata_i = 32'h0;
        wait_done(1'b1, "t4_store_timeout");
        step();
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
        check("t4_store_written", model_rd(32'h2000), 32'hDEAD_BEEF);
        repeat (2) step();

        // no ack: abort after 4 request cycles, zero data, one error pulse
        ack_delay = -1;
        push_bus(1'b0, 32'h3000, 32'h0, 4);
        exp_mem_q.push_back({1'b1, 32'h0});
        mem_ce_i = 1'b1; mem_addr_i = 32'h3000;
        wait_done(1'b1, "t5_abort_timeout");
        step();
        mem_ce_i = 1'b0;
        repeat (3) step();
        check("t5_err_count", err_cnt, 1);
        check("t5_err_delay", 64'(err_cyc - mem_done_cyc), 1);

        // reset in the second DBUSY cycle, then the load is re-issued
        ack_delay = 3;
        push_bus(1'b0, 32'h1000, 32'h0, 1);
        mem_ce_i = 1'b1; mem_addr_i = 32'h1000;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_bus_req", bus_req_o, 0);
        check("t6_rst_stallreq_mem", stallreq_mem_o, 0);
        check("t6_rst_state", dbg_state_o, 0);
        step();
        ack_delay = 1;
        push_bus(1'b0, 32'h1000, 32'h0, 2);
        exp_mem_q.push_back({1'b1, 32'h1111_2222});
        step();
        rst = 1'b0;
        wait_done(1'b1, "t6_reissue_timeout");
        step();
        mem_ce_i = 1'b0;
        repeat (3) step();
        check("t6_no_err_pulse", err_cnt, 1);

        check("exp_bus_q_empty", exp_bus_q.size(), 0);
        check("exp_if_q_empty", exp_if_q.size(), 0);
        check("exp_mem_q_empty", exp_mem_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port external memory bus between instruction fetch (IF) and data access (MEM) of the 5-stage core.
- Sits between pc_reg/if_id and mem on one side and the unified SRAM/bus on the other.
- Raises per-stage stall requests to ctrl until each access completes.
- Data accesses have fixed priority over fetches; a timeout counter guards against a dead bus.

Parameters:
- ADDR_W, 32, address width of both core ports and the bus.
- DATA_W, 32, data width.
- TIMEOUT, 255, cycles in BUSY without bus_ack_i before the access is aborted; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall_i  in  6  stall vector from ctrl; bit1 = IF/ID held, bit4 = MEM/WB held.
- if_ce_i  in  1  fetch request (pc_reg ce).
- if_addr_i  in  ADDR_W  fetch address.
- if_data_o  out  DATA_W  fetched instruction.
- mem_ce_i  in  1  data access request.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  ADDR_W  data address.
- mem_wdata_i  in  DATA_W  store data.
- mem_rdata_o  out  DATA_W  load data.
- stallreq_if_o  out  1  to ctrl: fetch not complete.
- stallreq_mem_o  out  1  to ctrl: data access not complete.
- bus_req_o  out  1  bus request, held until ack or timeout.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  ADDR_W  bus address.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_rdata_i  in  DATA_W  bus read data, valid with ack.
- bus_ack_i  in  1  transfer complete; may be asserted in the first cycle of bus_req_o.
- bus_err_o  out  1  one-cycle pulse on timeout abort.

Behaviour:
- States: IDLE, IBUSY, DBUSY.
- Pending flags: pend_d = mem_ce_i & !d_done; pend_i = if_ce_i & !i_done.
- IDLE:
  - pend_d → DBUSY; else pend_i → IBUSY; else stay.
  - The bus_* registers latch addr/we/wdata (we = 0 for IBUSY) at the same edge.
  - bus_req_o is registered high from the next cycle.
- IBUSY/DBUSY:
  - bus_req_o, bus_addr_o, bus_we_o, bus_wdata_o are held constant.
  - On bus_ack_i → IDLE.
  - On timeout_cnt == TIMEOUT-1 without ack → IDLE, completing the access with read data 0 and bus_err_o = 1 for one cycle (registered, the cycle after).
- Timeout counter: cleared on entering BUSY, increments each BUSY cycle without ack.
- Completion cycle: the cycle with ack or timeout in the corresponding BUSY state.
- Data return:
  - In the completion cycle, the return output is combinationally bus_rdata_i, or 0 on timeout.
  - Otherwise it is the hold register (i_hold / d_hold).
- Hold/done registers:
  - On completion for IF with stall_i[1] = 1: i_hold ← data, i_done ← 1.
  - On completion for MEM with stall_i[4] = 1: d_hold ← data, d_done ← 1.
  - i_done clears at any edge with stall_i[1] = 0; d_done clears at any edge with stall_i[4] = 0.
- stallreq_if_o = if_ce_i & !i_done & !(IBUSY & completion). stallreq_mem_o is the same form with mem/d/DBUSY.
  - Neither depends on stall_i, so there is no combinational loop through ctrl.
- Stores: mem_rdata_o is don't-care; completion semantics are identical.
- Simultaneous IF and MEM requests:
  - MEM is served first.
  - IF waits in IDLE and is granted the cycle after DBUSY ends.
  - Worst-case fetch latency = data access + 1 arbitration cycle + fetch.
- Minimum latency: request at cycle 0, bus_req_o at cycle 1, ack at cycle 1 → data returned and stall released at cycle 1.
- After completion the FSM always passes through IDLE (one idle bus cycle between transfers).
- Reset value of all outputs and registers is 0, FSM = IDLE.
  - Reset mid-transfer drops bus_req_o immediately (asynchronous); the transfer is abandoned, with no error pulse.
- ce deasserted while BUSY (pipeline flush): the transfer still runs to ack/timeout; the result is discarded because the done flag is cleared by the advancing stage.

Decomposition:
- Shared defines header: FSM state encodings (ARB_IDLE/ARB_IBUSY/ARB_DBUSY, 2 bits) and stall-bit indices (STALL_IF = 1, STALL_MEM = 4).
- One natural sub-module, arb_port_hold: the done flag, hold register and return mux, instantiated twice (IF, MEM).
- FSM and timeout counter live in the top.

Test Plan:
- IF only, ack on first req cycle, stall_i = 0:
  - if_addr 0x0000_0040, bus_rdata 0x2401_0005 → bus_req_o high 1 cycle.
  - if_data_o = 0x24010005 and stallreq_if_o low in that cycle.
- Simultaneous load 0x0000_1000 and fetch 0x0000_0044, ack after 2 cycles each:
  - Bus shows data address first, then fetch after 1 IDLE cycle.
  - stallreq_mem_o drops before stallreq_if_o.
- Fetch completes (0x8C22_0000) while stall_i[1] = 1 for 3 more cycles:
  - if_data_o holds 0x8C220000 and no new bus request is issued.
  - A new request is issued after stall_i[1] falls.
- Store 0xDEAD_BEEF to 0x0000_2000:
  - bus_we_o = 1, bus_wdata_o stable until ack.
  - stallreq_mem_o released on ack.
- No ack, TIMEOUT = 4:
  - bus_req_o high exactly 4 cycles, then bus_err_o pulses once.
  - mem_rdata_o = 0 and the stall is released.
- rst asserted in DBUSY cycle 2:
  - bus_req_o and stall requests go 0 immediately, no bus_err_o.
  - After release, the pending request is re-issued from IDLE.
